// File: rtl/prog_loader_if.sv
// Signal bundle for prog_loader: load control, SDRAM read port and the scheduler word stream.
// The slave modport is the loader's view; master is the system/bench side.
interface prog_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) ();

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_idx;
  logic              out_valid;
  logic              out_ready;
  logic              prog_loading;
  logic              done;

  modport master (
    output start, base_addr, length, mem_data, out_ready,
    input  mem_addr, mem_rd, out_data, out_idx, out_valid, prog_loading, done
  );

  modport slave (
    input  start, base_addr, length, mem_data, out_ready,
    output mem_addr, mem_rd, out_data, out_idx, out_valid, prog_loading, done
  );

endinterface

// File: rtl/prog_loader.sv
// Streams a LENGTH-word SDRAM image, in address order, to the scheduler frame-load port.
// Reads run ahead of the consumer and land in a small FIFO so consumer stalls never drop words.
module prog_loader #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  prog_loader_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W:0] OCC_LIM = (ADDR_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] ZERO_L  = (ADDR_W + 1)'(0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_issued;
  logic [ADDR_W:0]   r_xfer;
  logic              r_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [RD_LAT-1:0] r_infl;
  logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_valid;
  logic              r_loading;
  logic              r_done;

  logic              w_accept;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_last;
  logic              w_rd_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [ADDR_W:0]   w_occ;
  logic [RD_LAT-1:0] w_infl_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  // w_occ counts words already requested but not yet handed out, net of this cycle's pop;
  // keeping it below FIFO_DEPTH guarantees every outstanding read has a FIFO slot.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    w_rd_nxt    = 1'b0;
    w_addr_nxt  = r_mem_addr;
    w_pop       = r_valid & bus.out_ready;
    w_push      = r_infl[RD_LAT-1];
    w_last      = w_pop && (r_xfer == (r_len - ONE_L));
    w_occ       = r_issued - r_xfer - {{ADDR_W{1'b0}}, w_pop};
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept   = 1'b1;
          w_addr_nxt = bus.base_addr;
          if (bus.length != ZERO_L) begin
            w_state_nxt = S_LOAD;
            w_rd_nxt    = 1'b1;
          end else begin
            w_state_nxt = S_FINISH;
            w_rd_nxt    = 1'b0;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        w_issue = (r_issued < r_len) && (w_occ < OCC_LIM);
        if (w_issue) begin
          w_rd_nxt   = 1'b1;
          w_addr_nxt = r_base + r_issued[ADDR_W-1:0];
        end else begin
          w_rd_nxt   = 1'b0;
          w_addr_nxt = r_mem_addr;
        end
        if (w_last) begin
          w_state_nxt = S_FINISH;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_infl_nxt    = r_infl;
    w_infl_nxt[0] = r_mem_rd;
    for (int i = 1; i < RD_LAT; i++) begin
      w_infl_nxt[i] = r_infl[i-1];
    end
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + CNT_W'(1);
      2'b01:   w_cnt_nxt = r_cnt - CNT_W'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_base     <= {ADDR_W{1'b0}};
      r_len      <= ZERO_L;
      r_issued   <= ZERO_L;
      r_xfer     <= ZERO_L;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= {ADDR_W{1'b0}};
      r_infl     <= {RD_LAT{1'b0}};
      r_loading  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mem_rd   <= w_rd_nxt;
      r_mem_addr <= w_addr_nxt;
      r_infl     <= w_infl_nxt;
      r_loading  <= (w_state_nxt == S_LOAD);
      r_done     <= (w_state_nxt == S_FINISH);
      if (w_accept) begin
        r_base   <= bus.base_addr;
        r_len    <= bus.length;
        r_issued <= {{ADDR_W{1'b0}}, (bus.length != ZERO_L)};
        r_xfer   <= ZERO_L;
      end else begin
        if (w_issue) begin
          r_issued <= r_issued + ONE_L;
        end
        if (w_pop) begin
          r_xfer <= r_xfer + ONE_L;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo[i] <= {DATA_W{1'b0}};
      end
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_valid  <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= bus.mem_data;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_cnt   <= w_cnt_nxt;
      r_valid <= (w_cnt_nxt != {CNT_W{1'b0}});
    end
  end

  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_rd       = r_mem_rd;
  assign bus.out_data     = r_fifo[r_rd_ptr];
  assign bus.out_idx      = r_xfer[ADDR_W-1:0];
  assign bus.out_valid    = r_valid;
  assign bus.prog_loading = r_loading;
  assign bus.done         = r_done;

endmodule
